// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the iteration counter so it can hold WIDTH.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the sequential multiplier: sequencing, iteration count,
// handshake outputs and datapath strobes.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic done,
  output logic load_c,
  output logic shift_c,
  output logic last_c,
  output logic final_c
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // Strobes decoded from registered state only, plus start for the load.
  assign load_c  = start & ready;
  assign shift_c = (state == CALC);
  assign last_c  = shift_c && (cnt == CW'(WIDTH - 1));
  assign final_c = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential radix-2 multiplier, unsigned or two's-complement, one product
// bit per cycle; datapath registers live here, sequencing in seq_mult_ctrl.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 signed_mode,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned W = WIDTH;

  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] p_reg;
  logic         mode_q;
  logic         load_c;
  logic         shift_c;
  logic         last_c;
  logic         final_c;
  logic [W:0]   p_ext;
  logic [W:0]   b_ext;
  logic [W:0]   addend;
  logic [W:0]   sum_c;

  seq_mult_ctrl #(.WIDTH(W)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .load_c  (load_c),
    .shift_c (shift_c),
    .last_c  (last_c),
    .final_c (final_c)
  );

  // One guard bit: carry-out for unsigned, sign for signed; the sign-weighted
  // top multiplier bit turns the last step into a subtraction.
  always_comb begin
    p_ext  = {mode_q & p_reg[W-1], p_reg};
    b_ext  = {mode_q & b_reg[W-1], b_reg};
    addend = a_reg[0] ? b_ext : '0;
    sum_c  = (mode_q && last_c) ? (p_ext - addend) : (p_ext + addend);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      p_reg   <= '0;
      mode_q  <= 1'b0;
      product <= '0;
    end else begin
      if (load_c) begin
        a_reg  <= a_in;
        b_reg  <= b_in;
        p_reg  <= '0;
        mode_q <= signed_mode & SIGNED_EN;
      end else if (shift_c) begin
        p_reg <= sum_c[W:1];
        a_reg <= {sum_c[0], a_reg[W-1:1]};
      end
      if (final_c) product <= {p_reg, a_reg};
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: four builds (8-bit signed-capable, 8-bit unsigned
// only, 4-bit, 16-bit) against an arithmetic reference with cycle-level timing.
module tb_seq_mult_param;

  logic clk = 1'b0;
  logic rst;
  logic        start [4];
  logic [15:0] a     [4];
  logic [15:0] b     [4];
  logic        mode  [4];
  logic        rdy   [4];
  logic        bsy   [4];
  logic        dn    [4];
  logic [31:0] prod  [4];
  logic [15:0] p0;
  logic [15:0] p1;
  logic [7:0]  p2;
  logic [31:0] p3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .a_in(a[0][7:0]), .b_in(b[0][7:0]),
    .signed_mode(mode[0]), .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .product(p0));
  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .a_in(a[1][7:0]), .b_in(b[1][7:0]),
    .signed_mode(mode[1]), .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .product(p1));
  seq_mult_param #(.WIDTH(4), .SIGNED_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .a_in(a[2][3:0]), .b_in(b[2][3:0]),
    .signed_mode(mode[2]), .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .product(p2));
  seq_mult_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut3 (
    .clk(clk), .rst(rst), .start(start[3]), .a_in(a[3]), .b_in(b[3]),
    .signed_mode(mode[3]), .ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .product(p3));

  always_comb begin
    prod[0] = 32'(p0);
    prod[1] = 32'(p1);
    prod[2] = 32'(p2);
    prod[3] = p3;
  end

  function automatic int wid(input int k);
    case (k)
      2:       return 4;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic bit sen(input int k);
    return (k != 1);
  endfunction

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [31:0] ref_mult(input int w, input bit sgn,
                                           input logic [15:0] av, input logic [15:0] bv);
    longint x, y, mask;
    mask = (longint'(1) << w) - 1;
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (sgn) begin
      if (((x >> (w - 1)) & 1) != 0) x = x - (longint'(1) << w);
      if (((y >> (w - 1)) & 1) != 0) y = y - (longint'(1) << w);
    end
    return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", name, k, $time, got, exp);
    end
  endtask

  // Reference: an accepted operation completes W+1 edges after its accept edge.
  bit          act    [4];
  int          cnt    [4];
  bit          pm     [4];
  bit          edone  [4];
  logic [31:0] pend   [4];
  logic [31:0] eprod  [4];
  int          ndone_s[4];
  int          ndone_u[4];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        act[k]   <= 1'b0;
        cnt[k]   <= 0;
        edone[k] <= 1'b0;
        eprod[k] <= '0;
      end else begin
        edone[k] <= 1'b0;
        if (act[k]) begin
          cnt[k] <= cnt[k] + 1;
          if (cnt[k] + 1 == wid(k) + 1) begin
            act[k]   <= 1'b0;
            eprod[k] <= pend[k];
            edone[k] <= 1'b1;
            if (pm[k]) ndone_s[k] <= ndone_s[k] + 1;
            else       ndone_u[k] <= ndone_u[k] + 1;
          end
        end else if (start[k]) begin
          act[k]  <= 1'b1;
          cnt[k]  <= 0;
          pm[k]   <= mode[k] && sen(k);
          pend[k] <= ref_mult(wid(k), mode[k] && sen(k), a[k], b[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk("ready", k, 32'(rdy[k]), 32'(!act[k]));
      chk("busy", k, 32'(bsy[k]), 32'(act[k]));
      chk("done", k, 32'(dn[k]), 32'(edone[k]));
      chk("product", k, prod[k], eprod[k]);
    end
  end

  // Called #1 after an edge with the DUT idle; returns #1 after the done edge.
  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic m, output logic [31:0] res, output int lat);
    start[k] = 1'b1; a[k] = av; b[k] = bv; mode[k] = m;
    @(posedge clk); #1;
    start[k] = 1'b0; a[k] = 16'($urandom); b[k] = 16'($urandom); mode[k] = ~m;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (dn[k]) break;
    end
    chk("done_seen", k, 32'(dn[k]), 32'd1);
    res = prod[k];
  endtask

  function automatic logic [15:0] rand_op(input int k);
    logic [15:0] v;
    logic [15:0] msk;
    int w;
    w   = wid(k);
    msk = 16'((32'd1 << w) - 1);
    case ($urandom_range(7))
      0:       v = msk;
      1:       v = 16'(32'd1 << (w - 1));
      2:       v = '0;
      default: v = 16'($urandom);
    endcase
    return v & msk;
  endfunction

  task automatic stream(input int k);
    int cyc;
    cyc = 0;
    while ((ndone_s[k] < 1000 || ndone_u[k] < 1000) && cyc < 60000) begin
      start[k] = ($urandom_range(7) != 0);
      a[k] = rand_op(k);
      b[k] = rand_op(k);
      if (ndone_s[k] >= 1000)      mode[k] = 1'b0;
      else if (ndone_u[k] >= 1000) mode[k] = 1'b1;
      else                         mode[k] = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    start[k] = 1'b0;
    chk("stream_complete", k, 32'(cyc < 60000), 32'd1);
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    int ndn;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0; a[k] = '0; b[k] = '0; mode[k] = 1'b0;
      ndone_s[k] = 0; ndone_u[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 0, 32'(rdy[0]), 32'd1);
    chk("rst_busy", 0, 32'(bsy[0]), 32'd0);
    chk("rst_product", 3, prod[3], 32'd0);
    rst = 1'b0;

    // Accepted on the first edge after reset release.
    do_op(0, 16'h00FF, 16'h00FF, 1'b0, res, lat);
    chk("u255x255", 0, res, 32'hFE01);
    chk("u255x255_lat", 0, 32'(lat), 32'd9);
    @(posedge clk); #1;
    chk("done_one_cycle", 0, 32'(dn[0]), 32'd0);

    do_op(0, 16'h0080, 16'h0080, 1'b1, res, lat);
    chk("s_min_min", 0, res, 32'h4000);
    do_op(0, 16'h00FF, 16'h0005, 1'b1, res, lat);
    chk("s_m1x5", 0, res, 32'hFFFB);
    do_op(0, 16'h007F, 16'h0080, 1'b1, res, lat);
    chk("s_127xm128", 0, res, 32'hC080);
    do_op(1, 16'h00FF, 16'h0002, 1'b1, res, lat);
    chk("unsigned_only", 1, res, 32'h01FE);
    do_op(2, 16'h0008, 16'h0008, 1'b1, res, lat);
    chk("w4_min_min", 2, res, 32'h40);
    chk("w4_lat", 2, 32'(lat), 32'd5);
    do_op(3, 16'hFFFF, 16'hFFFF, 1'b0, res, lat);
    chk("w16_max_max", 3, res, 32'hFFFE0001);
    chk("w16_lat", 3, 32'(lat), 32'd17);

    // Starts while busy are ignored.
    start[0] = 1'b1; a[0] = 16'd7; b[0] = 16'd9; mode[0] = 1'b0;
    @(posedge clk); #1;
    ndn = 0;
    res = '0;
    for (int c = 1; c <= 20; c++) begin
      start[0] = (c == 3 || c == 5);
      a[0] = 16'd200; b[0] = 16'd100;
      @(posedge clk); #1;
      if (dn[0]) begin ndn++; res = prod[0]; end
    end
    start[0] = 1'b0;
    chk("busy_start_result", 0, res, 32'd63);
    chk("busy_start_dones", 0, 32'(ndn), 32'd1);

    // Reset mid-calculation aborts without a done pulse.
    start[0] = 1'b1; a[0] = 16'd10; b[0] = 16'd11; mode[0] = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b0;
    ndn = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dn[0]) ndn++;
    end
    rst = 1'b1;
    #1;
    chk("abort_no_done", 0, 32'(ndn), 32'd0);
    chk("abort_product", 0, prod[0], 32'd0);
    chk("abort_ready", 0, 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(0, 16'd3, 16'd4, 1'b0, res, lat);
    chk("after_abort", 0, res, 32'd12);
    chk("after_abort_lat", 0, 32'(lat), 32'd9);

    fork
      stream(2);
      stream(3);
    join
    repeat (20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
